// File: rtl/pc_unit_if.sv
// Program-counter unit bus: next-PC requests from the core and PC/RAS status back.
interface pc_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              hold;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              jump;
  logic              call;
  logic [ADDR_W-1:0] jump_target;
  logic              ret;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;
  logic              misalign_trap;

  modport master (
    output hold, branch_taken, branch_target, jump, call, jump_target, ret,
    input  pc, pc_plus, ras_empty, ras_full, ras_err, misalign_trap
  );

  modport slave (
    input  hold, branch_taken, branch_target, jump, call, jump_target, ret,
    output pc, pc_plus, ras_empty, ras_full, ras_err, misalign_trap
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: holds the PC and selects the next PC from sequential
// increment, branch, jump, call or return. Calls/returns use a circular
// return-address stack whose oldest entry is overwritten on overflow.
// Optional feature macro: PC_MISALIGN_TRAP_EN (trap on misaligned targets
// instead of silently clearing target bits [1:0]).
module pc_unit #(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       INC          = 4,
  parameter int unsigned       RAS_DEPTH    = 4,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'('h80)
) (
  input  logic      clock,
  input  logic      reset_n,
  pc_unit_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              push;
  logic              tgt_sel;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  assign pc_inc = pc_q + ADDR_W'(INC);

  // Next-PC selection in priority order hold > ret > call > jump > branch > sequential.
  always_comb begin
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    push    = 1'b0;
    tgt_sel = 1'b0;
    tgt     = pc_inc;
    if (bus.hold) begin
      pc_d = pc_q;
    end else if (bus.ret) begin
      if (cnt_q != '0) begin
        tgt_sel = 1'b1;
        tgt     = ras_q[ptr_q - PTR_ONE];
        ptr_d   = ptr_q - PTR_ONE;
        cnt_d   = cnt_q - CNT_ONE;
      end else begin
        pc_d  = pc_inc;
        err_d = 1'b1;
      end
    end else if (bus.call) begin
      push    = 1'b1;
      tgt_sel = 1'b1;
      tgt     = bus.jump_target;
      ptr_d   = ptr_q + PTR_ONE;
      if (cnt_q == CNT_FULL) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (bus.jump) begin
      tgt_sel = 1'b1;
      tgt     = bus.jump_target;
    end else if (bus.branch_taken) begin
      tgt_sel = 1'b1;
      tgt     = bus.branch_target;
    end else begin
      pc_d = pc_inc;
    end
    if (tgt_sel) begin
`ifdef PC_MISALIGN_TRAP_EN
      pc_d = (tgt[1:0] != 2'b00) ? TRAP_VECTOR : tgt;
`else
      pc_d = {tgt[ADDR_W-1:2], 2'b00};
`endif
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q, trap_d;

  // A trap is raised only for a target that was actually selected this cycle.
  always_comb begin
    trap_d = tgt_sel && (tgt[1:0] != 2'b00);
  end

  // Registered one-cycle misalignment pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) trap_q <= 1'b0;
    else          trap_q <= trap_d;
  end

  assign bus.misalign_trap = trap_q;
`else
  logic unused_trap_inputs;
  assign unused_trap_inputs = ^{tgt[1:0], TRAP_VECTOR};
  assign bus.misalign_trap  = 1'b0;
`endif

  // Control state: PC, stack pointer, occupancy and error pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Return-address storage; validity is tracked solely by the occupancy count.
  always_ff @(posedge clock) begin
    if (push) ras_q[ptr_q] <= pc_inc;
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus   = pc_inc;
  assign bus.ras_empty = (cnt_q == '0);
  assign bus.ras_full  = (cnt_q == CNT_FULL);
  assign bus.ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (scoreboard of expected post-edge outputs).
module tb_pc_unit;
  localparam int unsigned AW = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  pc_unit_if #(.ADDR_W(AW)) bus ();

  pc_unit #(
    .ADDR_W(AW), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(4), .TRAP_VECTOR(32'h80)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus;
    logic          err;
    logic          empty;
    logic          full;
    logic          trap;
  } obs_t;

  typedef struct packed {
    logic          h, r, c, j, b;
    logic [AW-1:0] jt, bt;
    obs_t          exp;
  } row_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic obs_t mk_obs(input logic [AW-1:0] epc, input logic err, emp, full, trap);
    obs_t o;
    o.pc      = epc;
    o.pc_plus = epc + 32'd4;
    o.err     = err;
    o.empty   = emp;
    o.full    = full;
    o.trap    = trap;
    return o;
  endfunction

  function automatic row_t mk(input logic h, r, c, j, b, input logic [AW-1:0] jt, bt, epc,
                              input logic err, emp, full, trap);
    row_t x;
    x.h = h; x.r = r; x.c = c; x.j = j; x.b = b;
    x.jt  = jt;
    x.bt  = bt;
    x.exp = mk_obs(epc, err, emp, full, trap);
    return x;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc      = bus.pc;
    o.pc_plus = bus.pc_plus;
    o.err     = bus.ras_err;
    o.empty   = bus.ras_empty;
    o.full    = bus.ras_full;
    o.trap    = bus.misalign_trap;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pc=%h plus=%h err=%b emp=%b full=%b trap=%b",
                     o.pc, o.pc_plus, o.err, o.empty, o.full, o.trap);
  endfunction

  task automatic apply(input row_t x);
    bus.hold          = x.h;
    bus.ret           = x.r;
    bus.call          = x.c;
    bus.jump          = x.j;
    bus.branch_taken  = x.b;
    bus.jump_target   = x.jt;
    bus.branch_target = x.bt;
    exp_q.push_back(x.exp);
  endtask

  task automatic idle_inputs();
    bus.hold = 1'b0; bus.ret = 1'b0; bus.call = 1'b0; bus.jump = 1'b0;
    bus.branch_taken = 1'b0; bus.jump_target = '0; bus.branch_target = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clock);
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, got;
    row_t rows[$];
    idle_inputs();
    #3;
    exp_q.push_back(mk_obs(32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    e = exp_q.pop_front(); got = sample(); checks++;
    if (got !== e) begin
      failures++; $display("FAIL reset_initial: got %s want %s", fmt(got), fmt(e));
    end
    @(negedge clock) reset_n = 1'b1;
    for (int k = 0; k < 16; k++) rows.push_back(mk(0,0,0,0,0, 0, 0, AW'(4*(k+1)), 0,1,0,0));
    foreach (rows[i]) begin
      apply(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL reset_run[%0d]: got %s want %s", i, fmt(got), fmt(e));
      end
    end
    reset_n = 1'b0;
    #1;
    exp_q.push_back(mk_obs(32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    e = exp_q.pop_front(); got = sample(); checks++;
    if (got !== e) begin
      failures++; $display("FAIL reset_async: got %s want %s", fmt(got), fmt(e));
    end
    @(negedge clock) reset_n = 1'b1;
    rows.delete();
    for (int k = 0; k < 3; k++) rows.push_back(mk(0,0,0,0,0, 0, 0, AW'(4*(k+1)), 0,1,0,0));
    foreach (rows[i]) begin
      apply(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL reset_release[%0d]: got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_branch_hold();
    obs_t e, got;
    row_t rows[$];
    do_reset();
    rows.push_back(mk(0,0,0,1,0, 32'h10,  0,       32'h10,  0,1,0,0));
    rows.push_back(mk(0,0,0,0,1, 0,       32'h100, 32'h100, 0,1,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,       0,       32'h104, 0,1,0,0));
    rows.push_back(mk(0,0,0,1,0, 32'h10,  0,       32'h10,  0,1,0,0));
    rows.push_back(mk(1,0,0,0,1, 0,       32'h100, 32'h10,  0,1,0,0));
    rows.push_back(mk(1,1,0,0,0, 0,       0,       32'h10,  0,1,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,       0,       32'h14,  0,1,0,0));
    foreach (rows[i]) begin
      apply(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL branch_hold[%0d]: got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_call_ret();
    obs_t e, got;
    row_t rows[$];
    do_reset();
    rows.push_back(mk(0,0,0,1,0, 32'h20,  0, 32'h20,  0,1,0,0));
    rows.push_back(mk(0,0,1,0,0, 32'h200, 0, 32'h200, 0,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,       0, 32'h204, 0,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,       0, 32'h208, 0,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 0,       0, 32'h24,  0,1,0,0));
    foreach (rows[i]) begin
      apply(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL call_ret[%0d]: got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_ras_overflow();
    obs_t e, got;
    row_t rows[$];
    do_reset();
    rows.push_back(mk(0,0,1,0,0, 32'h100, 0, 32'h100, 0,0,0,0));
    rows.push_back(mk(0,0,1,0,0, 32'h200, 0, 32'h200, 0,0,0,0));
    rows.push_back(mk(0,0,1,0,0, 32'h300, 0, 32'h300, 0,0,0,0));
    rows.push_back(mk(0,0,1,0,0, 32'h400, 0, 32'h400, 0,0,1,0));
    rows.push_back(mk(0,0,1,0,0, 32'h500, 0, 32'h500, 1,0,1,0));
    rows.push_back(mk(1,0,1,0,0, 32'h600, 0, 32'h500, 0,0,1,0));
    rows.push_back(mk(0,1,0,0,0, 0,       0, 32'h404, 0,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 0,       0, 32'h304, 0,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 0,       0, 32'h204, 0,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 0,       0, 32'h104, 0,1,0,0));
    rows.push_back(mk(0,1,0,0,0, 0,       0, 32'h108, 1,1,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,       0, 32'h10C, 0,1,0,0));
    foreach (rows[i]) begin
      apply(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL ras_overflow[%0d]: got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_priority();
    obs_t e, got;
    row_t rows[$];
    do_reset();
    rows.push_back(mk(0,0,0,1,0, 32'h4C,  0,       32'h4C,  0,1,0,0));
    rows.push_back(mk(0,0,1,0,0, 32'h600, 0,       32'h600, 0,0,0,0));
    rows.push_back(mk(0,1,1,0,0, 32'h700, 0,       32'h50,  0,1,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,       0,       32'h54,  0,1,0,0));
    rows.push_back(mk(0,1,0,0,0, 0,       0,       32'h58,  1,1,0,0));
    rows.push_back(mk(0,0,0,1,1, 32'h300, 32'h400, 32'h300, 0,1,0,0));
    rows.push_back(mk(0,0,1,0,0, 32'h800, 0,       32'h800, 0,0,0,0));
    rows.push_back(mk(1,1,0,0,0, 0,       0,       32'h800, 0,0,0,0));
    rows.push_back(mk(0,1,0,1,0, 32'h900, 0,       32'h304, 0,1,0,0));
    rows.push_back(mk(0,0,1,0,1, 32'hA00, 32'hB00, 32'hA00, 0,0,0,0));
    rows.push_back(mk(0,0,0,0,1, 0,       32'hB00, 32'hB00, 0,0,0,0));
    foreach (rows[i]) begin
      apply(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL priority[%0d]: got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_wrap_misalign();
    obs_t e, got;
    row_t rows[$];
`ifdef PC_MISALIGN_TRAP_EN
    logic [AW-1:0] pj = 32'h80, pi = 32'h84, pb = 32'h80, pc_call = 32'h80, pr = 32'h84;
    logic          tr = 1'b1;
`else
    logic [AW-1:0] pj = 32'h100, pi = 32'h104, pb = 32'h200, pc_call = 32'h300, pr = 32'h204;
    logic          tr = 1'b0;
`endif
    do_reset();
    rows.push_back(mk(0,0,0,1,0, 32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, 0,1,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,             0, 32'hFFFF_FFFC, 0,1,0,0));
    rows.push_back(mk(0,0,0,0,0, 0,             0, 32'h0,         0,1,0,0));
    rows.push_back(mk(0,0,0,1,0, 32'h102,       0, pj,            0,1,0,tr));
    rows.push_back(mk(0,0,0,0,0, 0,             0, pi,            0,1,0,0));
    rows.push_back(mk(0,0,0,0,1, 0,       32'h203, pb,            0,1,0,tr));
    rows.push_back(mk(0,0,1,0,0, 32'h302,       0, pc_call,       0,0,0,tr));
    rows.push_back(mk(0,1,0,0,0, 0,             0, pr,            0,1,0,0));
    foreach (rows[i]) begin
      apply(rows[i]); @(posedge clock); #1;
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL wrap_misalign[%0d]: got %s want %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no summary want summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_branch_hold();
    test_call_ret();
    test_ras_overflow();
    test_priority();
    test_wrap_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
